mux2x1_struct: RTL and testbench

- Structurally built 2-to-1 multiplexer; a gate-level per-bit cell is replicated WIDTH times.
- Primary output Y is purely combinational.
- A registered copy Y_q and a qualifier Y_valid are added for downstream synchronous consumers.
- Sits at leaf level in datapath select logic; default WIDTH=1 gives the classic single-bit mux.

---
 rtl/mux_pkg.sv | 7 +
 rtl/mux2x1_bit.sv | 19 +
 rtl/mux2x1_struct.sv | 54 +++++
 tb/tb_mux2x1_struct.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared select encodings for the structural 2:1 mux and its users.
package mux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux_pkg

// File: rtl/mux2x1_bit.sv
// One-bit 2:1 mux cell built only from gate primitives:
// y = (a & ~sel) | (b & sel).
module mux2x1_bit (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  wire sel_n;
  wire a_and;
  wire b_and;

  not u_not  (sel_n, sel);
  and u_and_a(a_and, a, sel_n);
  and u_and_b(b_and, b, sel);
  or  u_or   (y, a_and, b_and);

endmodule : mux2x1_bit

// File: rtl/mux2x1_struct.sv
// WIDTH-bit structural 2:1 mux. Y is purely combinational (replicated gate
// cells); Y_q is a one-cycle registered copy qualified by Y_valid, both
// cleared by a synchronous active-low reset.
module mux2x1_struct
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             Y_valid
);

  logic [WIDTH-1:0] y_reg_d;
  logic [WIDTH-1:0] y_reg_q;
  logic             valid_d;
  logic             valid_q;

  // Replicate the gate-level cell once per data bit; Sel fans out to all.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2x1_bit u_bit (
      .a  (A[i]),
      .b  (B[i]),
      .sel(Sel),
      .y  (Y[i])
    );
  end

  // Next-state: capture the live mux output; valid once out of reset.
  always_comb begin
    y_reg_d = Y;
    valid_d = 1'b1;
  end

  // Output register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg_q <= '0;
      valid_q <= 1'b0;
    end else begin
      y_reg_q <= y_reg_d;
      valid_q <= valid_d;
    end
  end

  assign Y_q     = y_reg_q;
  assign Y_valid = valid_q;

endmodule : mux2x1_struct

// File: tb/tb_mux2x1_struct.sv
// Self-checking bench: WIDTH=1 truth table and reset/latency sequences,
// WIDTH=8 directed and random regression against a behavioural model.
module tb_mux2x1_struct;
  import mux_pkg::*;

  logic       clk;
  logic       rst_n;

  logic       a1, b1, sel1;
  logic       y1, yq1, v1;

  logic [7:0] a8, b8;
  logic       sel8;
  logic [7:0] y8, yq8;
  logic       v8;

  int vectors;
  int miscompares;

  typedef struct {
    logic a;
    logic b;
    logic sel;
    logic y;
  } tt_vec_t;

  tt_vec_t tt[8];

  mux2x1_struct #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (a1),
    .B      (b1),
    .Sel    (sel1),
    .Y      (y1),
    .Y_q    (yq1),
    .Y_valid(v1)
  );

  mux2x1_struct #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (a8),
    .B      (b8),
    .Sel    (sel8),
    .Y      (y8),
    .Y_q    (yq8),
    .Y_valid(v8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick B when Sel is asserted, A otherwise.
  function automatic logic [7:0] ref_mux(input logic [7:0] a, input logic [7:0] b, input logic s);
    return (s == SEL_B) ? b : a;
  endfunction

  initial begin
    logic [7:0] exp_y, prev_y;
    logic       exp1, prev1;

    vectors     = 0;
    miscompares = 0;

    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tt[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tt[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tt[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tt[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tt[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    // Reset held for two edges with A=1, B=0, Sel=A.
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b0; sel1 = SEL_A;
    a8 = 8'h00; b8 = 8'h00; sel8 = SEL_A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_y1",   {7'b0, y1},  8'h01);
    check("rst_yq1",  {7'b0, yq1}, 8'h00);
    check("rst_v1",   {7'b0, v1},  8'h00);
    check("rst_yq8",  yq8,         8'h00);
    check("rst_v8",   {7'b0, v8},  8'h00);

    // Release: first edge loads Y_q and sets valid.
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_yq1",  {7'b0, yq1}, 8'h01);
    check("rel_v1",   {7'b0, v1},  8'h01);
    check("rel_v8",   {7'b0, v8},  8'h01);

    // Exhaustive truth table; Y checked in the same step, Y_q one edge later.
    prev1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a1 = tt[i].a; b1 = tt[i].b; sel1 = tt[i].sel;
      #1;
      check($sformatf("tt_y[%0d]", i), {7'b0, y1}, {7'b0, tt[i].y});
      @(negedge clk);
      check($sformatf("tt_yq[%0d]", i), {7'b0, yq1}, {7'b0, tt[i].y});
      prev1 = tt[i].y;
    end

    // Latency: Sel flips between edges, Y moves at once, Y_q after next edge.
    a1 = 1'b0; b1 = 1'b1; sel1 = SEL_A;
    @(negedge clk);
    check("lat_yq_pre", {7'b0, yq1}, 8'h00);
    sel1 = SEL_B;
    #1;
    check("lat_y",      {7'b0, y1},  8'h01);
    check("lat_yq_old", {7'b0, yq1}, 8'h00);
    @(negedge clk);
    check("lat_yq_new", {7'b0, yq1}, 8'h01);
    check("lat_v",      {7'b0, v1},  8'h01);

    // Mid-operation reset for one edge.
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_yq1", {7'b0, yq1}, 8'h00);
    check("mid_v1",  {7'b0, v1},  8'h00);
    check("mid_y1",  {7'b0, y1},  8'h01);
    check("mid_v8",  {7'b0, v8},  8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_v1", {7'b0, v1}, 8'h01);

    // Wide instance directed pattern.
    a8 = 8'hA5; b8 = 8'h3C; sel8 = SEL_A;
    #1;
    check("w_y_a", y8, 8'hA5);
    @(negedge clk);
    check("w_yq_a", yq8, 8'hA5);
    sel8 = SEL_B;
    #1;
    check("w_y_b",  y8,  8'h3C);
    check("w_yq_hold", yq8, 8'hA5);
    @(negedge clk);
    check("w_yq_b", yq8, 8'h3C);

    // Random regression, one vector per cycle.
    prev_y = 8'h3C;
    for (int n = 0; n < 1000; n++) begin
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      sel8 = 1'($urandom);
      exp_y = ref_mux(a8, b8, sel8);
      #1;
      check("rnd_y", y8, exp_y);
      @(negedge clk);
      check("rnd_yq", yq8, exp_y);
      check("rnd_v",  {7'b0, v8}, 8'h01);
      prev_y = exp_y;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mux2x1_struct
